// File: rtl/counter_ctrl_if.sv
// Bus between counter_ctrl and the binary counter it drives, plus its
// configuration/command inputs.
//   start, stop     one-cycle commands
//   mode            0 = one-shot, 1 = periodic (sampled with start)
//   period          terminal count value (sampled with start)
//   prescale        tick every prescale+1 RUN cycles (sampled with start)
//   q               counter's registered output, fed back for compare
//   ce, sclr        count enable / synchronous clear to the counter
//   tc              one-cycle terminal tick pulse
//   done, busy      status
interface counter_ctrl_if #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned PSWIDTH = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [DWIDTH-1:0]  period;
  logic [PSWIDTH-1:0] prescale;
  logic [DWIDTH-1:0]  q;
  logic               ce;
  logic               sclr;
  logic               tc;
  logic               done;
  logic               busy;

  // Environment side: issues commands/config and supplies the counter value.
  modport master (
    output start, stop, mode, period, prescale, q,
    input  ce, sclr, tc, done, busy
  );

  // Controller side.
  modport slave (
    input  start, stop, mode, period, prescale, q,
    output ce, sclr, tc, done, busy
  );
endinterface

// File: rtl/counter_ctrl.sv
// Control stage for an external binary counter, forming a programmable timer
// with period (PERIOD+1)*(PRESCALE+1) clock cycles.
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   counter_ctrl_if.slave: commands/config in, counter q in,
//         ce/sclr/tc/done/busy out
// Outputs are decoded only from registered state and the compare against q,
// so there is no combinational path from the command/config inputs.
module counter_ctrl #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned PSWIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  counter_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [PSWIDTH-1:0] pcnt_q, pcnt_d;
  logic               mode_q, mode_d;
  logic [DWIDTH-1:0]  period_q, period_d;
  logic [PSWIDTH-1:0] pscl_q, pscl_d;

  logic tick;
  logic term;
  logic load;
  logic ce, sclr, tc, done, busy;

  assign tick = (state_q == StRun) && (pcnt_q == pscl_q);
  assign term = (bus.q == period_q);
  // STOP wins over START, so a simultaneous pair never reloads the shadows.
  assign load = bus.start && !bus.stop;

  always_comb begin
    state_d  = state_q;
    pcnt_d   = '0;
    mode_d   = mode_q;
    period_d = period_q;
    pscl_d   = pscl_q;
    ce       = 1'b0;
    sclr     = 1'b0;
    tc       = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;

    if (load) begin
      mode_d   = bus.mode;
      period_d = bus.period;
      pscl_d   = bus.prescale;
    end

    if (state_q == StRun) begin
      pcnt_d = tick ? '0 : pcnt_q + PSWIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (load) state_d = StClear;
      end
      StClear: begin
        ce      = 1'b1;
        sclr    = 1'b1;
        busy    = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (tick) begin
          tc = term;
          if (term && !mode_q) begin
            // One-shot end: leave q parked at the terminal value.
            state_d = StDone;
          end else begin
            ce   = 1'b1;
            sclr = term;
          end
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Commands override the per-state transitions; restart from any state.
    if (bus.stop) begin
      state_d = StIdle;
    end else if (bus.start) begin
      state_d = StClear;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pcnt_q   <= '0;
      mode_q   <= 1'b0;
      period_q <= '0;
      pscl_q   <= '0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      pscl_q   <= pscl_d;
    end
  end

  assign bus.ce   = ce;
  assign bus.sclr = sclr;
  assign bus.tc   = tc;
  assign bus.done = done;
  assign bus.busy = busy;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with a behavioural counter closing the q loop.
// Directed stimulus pushes cycle-tagged expectations into a scoreboard queue;
// a monitor on the falling edge pops and compares them.
// Expected flags are {ce, sclr, tc, done, busy}.
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int         cyc;
    logic [4:0] flags;
    int         qv;     // negative: q not checked
    string      nm;
  } exp_t;

  exp_t sb[$];

  counter_ctrl_if #(.DWIDTH(8), .PSWIDTH(8)) bus ();

  counter_ctrl #(.DWIDTH(8), .PSWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter model driven by ce/sclr.
  always @(posedge clk or posedge rst) begin
    if (rst)         bus.q <= '0;
    else if (bus.ce) bus.q <= bus.sclr ? 8'd0 : bus.q + 8'd1;
  end

  task automatic ex(input int c, input logic [4:0] f, input int qv, input string nm);
    exp_t e;
    e.cyc = c; e.flags = f; e.qv = qv; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic cfg(input logic m, input logic [7:0] p, input logic [7:0] ps);
    bus.mode = m; bus.period = p; bus.prescale = ps;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; step(1); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; step(1); bus.stop = 1'b0;
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        logic [4:0] got;
        e = sb.pop_front();
        got = {bus.ce, bus.sclr, bus.tc, bus.done, bus.busy};
        n_vec++;
        if (e.cyc < cyc) begin
          n_err++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.nm, e.cyc, cyc);
        end else if (got !== e.flags || (e.qv >= 0 && int'(bus.q) != e.qv)) begin
          n_err++;
          $display("FAIL %s cyc=%0d flags got=%b want=%b q got=%0d want=%0d",
                   e.nm, cyc, got, e.flags, bus.q, e.qv);
        end
      end
    end
  end

  initial begin
    int b;
    int guard;
    bus.start = 1'b0; bus.stop = 1'b0;
    cfg(1'b0, 8'd0, 8'd0);

    // Reset
    step(3);
    rst = 1'b0;
    b = cyc;
    ex(b,     5'b00000, 0, "rst_idle0");
    ex(b + 1, 5'b00000, 0, "rst_idle1");
    wait_to(b + 2);

    // Periodic, PERIOD=2 PRESCALE=1
    b = cyc;
    ex(b,      5'b00000, 0, "per_idle");
    ex(b + 1,  5'b11001, -1, "per_clear");
    ex(b + 2,  5'b00001, 0, "per_c2");
    ex(b + 3,  5'b10001, 0, "per_tick3");
    ex(b + 4,  5'b00001, 1, "per_c4");
    ex(b + 5,  5'b10001, 1, "per_tick5");
    ex(b + 6,  5'b00001, 2, "per_c6");
    ex(b + 7,  5'b11101, 2, "per_tc7");
    ex(b + 8,  5'b00001, 0, "per_wrap8");
    ex(b + 13, 5'b11101, 2, "per_tc13");
    ex(b + 14, 5'b00001, 0, "per_wrap14");
    ex(b + 19, 5'b11101, 2, "per_tc19");
    ex(b + 20, 5'b00001, 0, "per_c20");
    ex(b + 21, 5'b00000, 0, "per_stopped");
    cfg(1'b1, 8'd2, 8'd1);
    pulse_start();
    wait_to(b + 20);
    pulse_stop();

    // STOP at cycle 4 of a periodic run
    step(1);
    b = cyc;
    ex(b + 1, 5'b11001, -1, "stop_clear");
    ex(b + 4, 5'b00001, 1, "stop_c4");
    ex(b + 5, 5'b00000, 1, "stop_c5");
    ex(b + 6, 5'b00000, 1, "stop_frozen");
    pulse_start();
    wait_to(b + 4);
    pulse_stop();
    wait_to(b + 7);

    // START and STOP together mid-RUN -> IDLE
    b = cyc;
    ex(b + 1, 5'b11001, -1, "ss_clear");
    ex(b + 3, 5'b10001, 0, "ss_tick");
    ex(b + 4, 5'b00000, 1, "ss_idle");
    ex(b + 5, 5'b00000, 1, "ss_idle2");
    pulse_start();
    wait_to(b + 3);
    cfg(1'b0, 8'd9, 8'd0);
    bus.start = 1'b1; bus.stop = 1'b1;
    step(1);
    bus.start = 1'b0; bus.stop = 1'b0;
    wait_to(b + 6);

    // One-shot, PERIOD=3 PRESCALE=0, then restart and stop
    b = cyc;
    ex(b + 1,  5'b11001, -1, "os_clear");
    ex(b + 2,  5'b10001, 0, "os_q0");
    ex(b + 3,  5'b10001, 1, "os_q1");
    ex(b + 4,  5'b10001, 2, "os_q2");
    ex(b + 5,  5'b00101, 3, "os_tc");
    ex(b + 6,  5'b00010, 3, "os_done6");
    ex(b + 7,  5'b00010, 3, "os_done7");
    ex(b + 8,  5'b00010, 3, "os_done_start");
    ex(b + 9,  5'b11001, -1, "os_restart_clear");
    ex(b + 10, 5'b10001, 0, "os_restart_run");
    ex(b + 11, 5'b00000, 1, "os_stopped");
    cfg(1'b0, 8'd3, 8'd0);
    pulse_start();
    wait_to(b + 8);
    pulse_start();
    wait_to(b + 10);
    pulse_stop();
    wait_to(b + 12);

    // PERIOD=0 periodic: terminal on every tick
    b = cyc;
    ex(b + 1, 5'b11001, -1, "p0_clear");
    ex(b + 2, 5'b11101, 0, "p0_c2");
    ex(b + 3, 5'b11101, 0, "p0_c3");
    ex(b + 4, 5'b11101, 0, "p0_c4");
    ex(b + 5, 5'b11101, 0, "p0_c5");
    ex(b + 6, 5'b00000, 0, "p0_stopped");
    cfg(1'b1, 8'd0, 8'd0);
    pulse_start();
    wait_to(b + 5);
    pulse_stop();
    wait_to(b + 7);

    // Config changes mid-RUN ignored until START
    b = cyc;
    ex(b + 3,  5'b10001, 0, "sh_tick3");
    ex(b + 5,  5'b10001, 1, "sh_tick5");
    ex(b + 7,  5'b11101, 2, "sh_tc7");
    ex(b + 8,  5'b00001, 0, "sh_c8");
    ex(b + 9,  5'b11001, -1, "sh_reclear");
    ex(b + 10, 5'b11101, 0, "sh_new_cfg");
    ex(b + 11, 5'b00000, 0, "sh_stopped");
    cfg(1'b1, 8'd2, 8'd1);
    pulse_start();
    wait_to(b + 2);
    cfg(1'b1, 8'd0, 8'd0);
    wait_to(b + 8);
    pulse_start();
    wait_to(b + 10);
    pulse_stop();
    wait_to(b + 12);

    // Asynchronous reset mid-RUN drops ce within the reset pulse
    b = cyc;
    ex(b + 1, 5'b11001, -1, "ar_clear");
    ex(b + 2, 5'b00000, 0, "ar_in_reset");
    ex(b + 3, 5'b00000, 0, "ar_idle3");
    ex(b + 4, 5'b00000, 0, "ar_idle4");
    cfg(1'b1, 8'd5, 8'd0);
    pulse_start();
    wait_to(b + 2);
    #2 rst = 1'b1;
    wait_to(b + 3);
    rst = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      step(1);
      guard++;
    end
    if (sb.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Control stage that sits directly upstream of the binary counter and drives its CE and SCLR inputs. It turns a free-running clock into prescaled count enables and watches the counter's Q to detect the terminal value. It also supports periodic (auto-wrap) and one-shot modes with start/stop control. Together the two blocks form a programmable timer: period = (PERIOD+1)·(PRESCALE+1) clock cycles.

## Interface
- DWIDTH, 8, width of counter value; must match the driven counter
- PSWIDTH, 8, width of prescaler
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request: latch config, clear counter, begin counting
- STOP  in  1  one-cycle request: halt, return to IDLE
- MODE  in  1  0 = one-shot, 1 = periodic; sampled with START
- PERIOD  in  DWIDTH  terminal count value; sampled with START
- PRESCALE  in  PSWIDTH  CE issued every PRESCALE+1 RUN cycles; sampled with START
- Q  in  DWIDTH  current counter value (the counter's registered output)
- CE  out  1  count enable to counter
- SCLR  out  1  synchronous clear to counter (meaningful only with CE=1)
- TC  out  1  one-cycle pulse on the terminal tick
- DONE  out  1  high in DONE state (one-shot finished)
- BUSY  out  1  high in CLEAR and RUN

## Operation
- Shadow registers mode_r, period_r, pscl_r load on accepted START only; mid-run input changes are ignored.
- Prescaler pcnt (PSWIDTH bits): 0 on entering RUN; increments each RUN cycle; tick = (state==RUN && pcnt==pscl_r); on tick pcnt returns to 0.
- FSM states:
  - IDLE: CE=0, SCLR=0. START -> CLEAR.
  - CLEAR: one cycle, CE=1, SCLR=1. Always -> RUN with pcnt=0.
  - RUN: CE=tick.
    - On tick with Q != period_r: SCLR=0, TC=0, stay.
    - On tick with Q == period_r and mode_r=1: SCLR=1, TC=1, stay (wrap).
    - On tick with Q == period_r and mode_r=0: CE=0, SCLR=0, TC=1, -> DONE. Q holds period_r.
  - DONE: CE=0, DONE=1. START -> CLEAR; STOP -> IDLE.
- STOP in any state -> IDLE next cycle. STOP has priority over START in the same cycle.
- START in RUN or CLEAR restarts: reload shadows, -> CLEAR.
- CE, SCLR, TC are decoded from state/pcnt registers plus the compare against Q. There is no combinational path from START/STOP/MODE/PERIOD/PRESCALE to any output.
- Compare is full DWIDTH equality. The counter is never driven past period_r, so it never wraps through all-ones unless PERIOD = 2^DWIDTH-1.

## Timing
- Reset: state=IDLE, pcnt=0, shadows=0; CE=SCLR=TC=DONE=BUSY=0. Reset during RUN drops CE within the reset assertion (asynchronous). The counter's own reset is wired separately at integration.
- START sampled at cycle n: CLEAR is active in cycle n+1 (CE=SCLR=1, BUSY=1), and Q=0 from n+2.
- First tick occurs at cycle n+2+PRESCALE. Q increments one cycle after each tick.
- Periodic: TC pulses every (period_r+1)·(pscl_r+1) cycles. Q sequence is 0..period_r, then 0.
- One-shot: TC and the DONE transition both occur on the (period_r+1)-th tick. DONE=1 from the next cycle.
- PRESCALE=0: tick every RUN cycle.
- PERIOD=0: every tick is terminal. Periodic gives CE+SCLR each tick with Q stuck at 0; one-shot gives DONE after the first tick.
- STOP at cycle m: CE=0 from m+1; Q holds its value. BUSY/DONE=0 from m+1.

## Test plan
- Reset with all inputs 0, then release -> CE=SCLR=TC=DONE=BUSY=0; after a mid-RUN RST pulse, CE=0 immediately and state=IDLE.
- MODE=1, PERIOD=2, PRESCALE=1, START at cycle 0:
  - CE=SCLR=1 at cycle 1.
  - Ticks at cycles 3, 5, 7, ...
  - TC and SCLR at cycle 7; Q=0 at cycle 8.
  - TC repeats every 6 cycles (13, 19, ...).
- MODE=0, PERIOD=3, PRESCALE=0, START at 0:
  - Q = 0, 1, 2, 3 at cycles 2-5.
  - TC at cycle 5 with CE=0.
  - DONE=1 from cycle 6 and Q holds 3.
  - START again -> CLEAR, DONE=0.
- STOP at cycle 4 of the periodic run above -> CE=0 from cycle 5, Q frozen; START and STOP in the same cycle -> IDLE.
- PERIOD=0, PRESCALE=0, MODE=1 -> CE=SCLR=TC=1 every RUN cycle, Q=0 throughout.
- PERIOD and PRESCALE changed mid-RUN without START -> period unchanged; START mid-RUN -> CLEAR next cycle with new values applied.
